// File: rtl/lfsr_dither.sv
// Fibonacci XNOR LFSR dither source with runtime taps, uniform/triangular
// sample shaping, warm-up qualification and lock-up state recovery.
module lfsr_dither #(
  parameter int                       NUM_LFSR_BITS = 16,
  parameter int                       NUM_PRND_BITS = 5,
  parameter logic [NUM_LFSR_BITS-1:0] DEFAULT_SEED  = '0,
  parameter int                       WARMUP        = NUM_LFSR_BITS
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     load,
  input  logic [NUM_LFSR_BITS-1:0] seed,
  input  logic [NUM_LFSR_BITS-1:0] taps,
  input  logic [1:0]               mode,
  output logic [NUM_PRND_BITS:0]   rnd,
  output logic                     rnd_valid,
  output logic                     lockup
);

  localparam logic [1:0] MODE_TRI    = 2'b01;
  localparam logic [1:0] MODE_FREEZE = 2'b10;
  localparam logic [7:0] WARMUP_C    = 8'(WARMUP);

  logic [NUM_LFSR_BITS-1:0] lfsr_q, lfsr_d;
  logic [NUM_PRND_BITS:0]   rnd_q, rnd_d;
  logic [7:0]               cnt_q, cnt_d;
  logic                     valid_q, valid_d;
  logic                     lockup_q, lockup_d;

  logic                     feedback;
  logic                     step;
  logic [NUM_LFSR_BITS-1:0] cand;
  logic [NUM_PRND_BITS-1:0] lo, hi;

  always_comb begin
    feedback = ~^(lfsr_q & taps);
    step     = enable & ~load & (mode != MODE_FREEZE);
    cand     = load ? seed : {lfsr_q[NUM_LFSR_BITS-2:0], feedback};

    lfsr_d   = lfsr_q;
    rnd_d    = rnd_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    lockup_d = 1'b0;

    // All-ones is the XNOR lock-up state; divert it to all-zeros instead.
    if (load || step) begin
      if (&cand) begin
        lfsr_d   = '0;
        lockup_d = 1'b1;
      end else begin
        lfsr_d   = cand;
      end
    end

    lo = lfsr_d[NUM_PRND_BITS-1:0];
    hi = lfsr_d[2*NUM_PRND_BITS-1:NUM_PRND_BITS];

    if (load) begin
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (step) begin
      if (mode == MODE_TRI) rnd_d = {1'b0, lo} + {1'b0, hi};
      else                  rnd_d = {1'b0, lo};
      if (cnt_q != '1) cnt_d = cnt_q + 8'd1;
      if (cnt_d >= WARMUP_C) valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr_q   <= DEFAULT_SEED;
      rnd_q    <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      rnd_q    <= rnd_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      lockup_q <= lockup_d;
    end
  end

  assign rnd       = rnd_q;
  assign rnd_valid = valid_q;
  assign lockup    = lockup_q;

endmodule

// File: tb/tb_lfsr_dither.sv
// Self-checking bench for lfsr_dither: directed scenarios plus a randomized
// phase, all compared against a behavioural model kept here.
module tb_lfsr_dither;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        load;
  logic [15:0] seed;
  logic [15:0] taps;
  logic [1:0]  mode;
  logic [5:0]  rnd;
  logic        rnd_valid;
  logic        lockup;

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_lfsr;
  logic [5:0]  m_rnd;
  logic        m_valid;
  logic        m_lock;
  int          m_steps;

  lfsr_dither #(
    .NUM_LFSR_BITS(16),
    .NUM_PRND_BITS(5),
    .DEFAULT_SEED (16'h0000),
    .WARMUP       (16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .load     (load),
    .seed     (seed),
    .taps     (taps),
    .mode     (mode),
    .rnd      (rnd),
    .rnd_valid(rnd_valid),
    .lockup   (lockup)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lfsr  = 16'h0000;
    m_rnd   = 6'd0;
    m_valid = 1'b0;
    m_lock  = 1'b0;
    m_steps = 0;
  endtask

  // Behavioural view: count tapped ones, even parity means feedback 1.
  task automatic model_edge(input logic ld, input logic en, input logic [1:0] md,
                            input logic [15:0] sd, input logic [15:0] tp);
    logic [15:0] nxt;
    int ones;
    m_lock = 1'b0;
    if (ld) begin
      nxt     = sd;
      m_steps = 0;
      m_valid = 1'b0;
    end else if (en && md != 2'd2) begin
      ones = 0;
      for (int i = 0; i < 16; i++) if (m_lfsr[i] && tp[i]) ones++;
      nxt = (m_lfsr << 1) | ((ones % 2 == 0) ? 16'd1 : 16'd0);
      m_steps++;
      if (m_steps >= 16) m_valid = 1'b1;
    end else begin
      return;
    end
    if (nxt == 16'hFFFF) begin
      nxt    = 16'h0000;
      m_lock = 1'b1;
    end
    m_lfsr = nxt;
    if (!ld) m_rnd = (md == 2'd1) ? 6'(nxt % 32 + (nxt / 32) % 32) : 6'(nxt % 32);
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".lfsr"},   32'(dut.lfsr_q), 32'(m_lfsr));
    check({tag, ".rnd"},    32'(rnd),        32'(m_rnd));
    check({tag, ".valid"},  32'(rnd_valid),  32'(m_valid));
    check({tag, ".lockup"}, 32'(lockup),     32'(m_lock));
  endtask

  task automatic cyc(input logic ld, input logic en, input logic [1:0] md,
                     input logic [15:0] sd, input logic [15:0] tp, input string tag);
    @(negedge clock);
    load = ld; enable = en; mode = md; seed = sd; taps = tp;
    @(posedge clock);
    model_edge(ld, en, md, sd, tp);
    #1;
    compare_all(tag);
  endtask

  initial begin
    logic        lock_seen;
    logic [15:0] r_seed;
    logic [1:0]  r_mode;
    logic        r_ld;

    reset = 1'b0; enable = 1'b0; load = 1'b0; seed = '0; taps = '0; mode = 2'd0;
    model_reset();
    #23;
    check("reset.lfsr",   32'(dut.lfsr_q), 32'h0);
    check("reset.rnd",    32'(rnd),        32'h0);
    check("reset.valid",  32'(rnd_valid),  32'h0);
    check("reset.lockup", 32'(lockup),     32'h0);
    @(negedge clock);
    reset = 1'b1;

    // Full maximal-length period with taps D008.
    cyc(1'b0, 1'b1, 2'd0, 16'h0, 16'hD008, "step1");
    check("step1.lfsr_const", 32'(dut.lfsr_q), 32'h0001);
    check("step1.rnd_const",  32'(rnd),        32'h01);
    lock_seen = lockup;
    for (int s = 2; s <= 65535; s++) begin
      cyc(1'b0, 1'b1, 2'd0, 16'h0, 16'hD008, "period");
      lock_seen = lock_seen | lockup;
      if (s == 15) check("warm15.valid", 32'(rnd_valid), 32'h0);
      if (s == 16) check("warm16.valid", 32'(rnd_valid), 32'h1);
    end
    check("period.lfsr_zero", 32'(dut.lfsr_q), 32'h0000);
    check("period.no_lockup", 32'(lock_seen),  32'h0);

    // Loading the lock-up state.
    cyc(1'b1, 1'b0, 2'd0, 16'hFFFF, 16'hD008, "loadFFFF");
    check("loadFFFF.lockup_const", 32'(lockup),    32'h1);
    check("loadFFFF.valid_const",  32'(rnd_valid), 32'h0);
    cyc(1'b0, 1'b0, 2'd0, 16'h0, 16'hD008, "idle");
    check("idle.lockup_const", 32'(lockup), 32'h0);

    // Triangular step from 01FF with empty taps.
    cyc(1'b1, 1'b0, 2'd0, 16'h01FF, 16'h0, "load01FF");
    cyc(1'b0, 1'b1, 2'd1, 16'h0, 16'h0, "tri");
    check("tri.lfsr_const", 32'(dut.lfsr_q), 32'h03FF);
    check("tri.rnd_const",  32'(rnd),        32'd62);

    // Load wins over enable, then freeze.
    cyc(1'b1, 1'b1, 2'd0, 16'h1234, 16'hD008, "loadEn");
    check("loadEn.lfsr_const", 32'(dut.lfsr_q), 32'h1234);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b1, 2'd2, 16'h0, 16'hD008, "freeze");
      check("freeze.lfsr_const", 32'(dut.lfsr_q), 32'h1234);
      check("freeze.rnd_const",  32'(rnd),        32'd62);
    end
    // Warm-up restarts from zero after the load.
    for (int s = 1; s <= 16; s++) begin
      cyc(1'b0, 1'b1, 2'd0, 16'h0, 16'hD008, "rewarm");
      if (s == 15) check("rewarm15.valid", 32'(rnd_valid), 32'h0);
      if (s == 16) check("rewarm16.valid", 32'(rnd_valid), 32'h1);
    end

    // Randomized mix of loads, steps, taps and modes.
    for (int k = 0; k < 400; k++) begin
      r_ld   = ($urandom_range(0, 15) == 0);
      r_mode = 2'($urandom_range(0, 3));
      r_seed = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      cyc(r_ld, 1'($urandom_range(0, 1)), r_mode, r_seed,
          ($urandom_range(0, 1) != 0) ? 16'hD008 : 16'($urandom), "rand");
    end

    // Asynchronous reset between edges.
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    check("async.lfsr",   32'(dut.lfsr_q), 32'h0);
    check("async.rnd",    32'(rnd),        32'h0);
    check("async.valid",  32'(rnd_valid),  32'h0);
    check("async.lockup", 32'(lockup),     32'h0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    cyc(1'b0, 1'b1, 2'd0, 16'h0, 16'hD008, "postreset");
    check("postreset.lfsr_const", 32'(dut.lfsr_q), 32'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
